manchester_tx_arbiter: RTL and testbench
========================================

Name: manchester_tx_arbiter

Overview:
Round-robin frame arbiter that shares one Manchester transmitter between N byte-stream requesters. It grants one requester per frame and streams that requester's bytes to the transmitter's valid/rdy/data port with no gaps. Between frames it waits for the transmitter to finish its idle bits (txen low), so frames from different requesters never merge. Sits directly upstream of the transmitter.

Parameters:
N_REQ, 2, number of requesters (2..8)
MAX_FRAME, 16, max bytes per frame; a frame is force-terminated after this many bytes (1..255)
PREAMBLE, 8'h55, preamble byte value, used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester byte valid
req_data  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  N_REQ  byte is the last byte of the frame
req_ready  out  N_REQ  byte accepted when req_valid[i] && req_ready[i]
tx_valid  out  1  to transmitter valid
tx_data  out  8  to transmitter data
tx_rdy  in  1  transmitter rdy; byte handed off when tx_valid && tx_rdy
tx_txen  in  1  transmitter txen; low means the transmitter is idle
busy  out  1  high in every state except ARB
grant_id  out  $clog2(N_REQ)  current or most recent grantee
frame_abort  out  1  one-cycle pulse on underrun or truncation

Behaviour:
- Reset values: tx_valid=0, tx_data=0, req_ready=0, busy=0, grant_id=0, frame_abort=0, rr pointer=N_REQ-1 (requester 0 wins first), state=ARB.
- Datapath: one-entry holding register (hold_data, hold_last, hold_full).
  - tx_valid=hold_full; tx_data=hold_data.
  - req_ready[g]=(state==SEND) && (!hold_full || tx_rdy), for the grantee g only; all other bits 0.
- Handoff and load in the same cycle: the register takes the new byte, stays full, and there is no bubble.
- Byte counter: 8 bits, cleared on grant, incremented on each accept.
  - An accepted byte is treated as last if req_last is set or count==MAX_FRAME-1.
- States:
  - ARB: if any req_valid, pick the first valid requester searching from ptr+1 with wrap. Set grant_id and ptr=winner, clear the count, go to SEND. If none are valid, stay in ARB.
  - SEND: accept bytes from the grantee.
    - After accepting the last byte, stop asserting req_ready. Go to FLUSH once that byte is handed off.
    - Underrun (hold empty, grantee req_valid low, no last byte yet): pulse frame_abort and go to DRAIN. The transmitter then closes the frame itself.
  - FLUSH: held for exactly one cycle; go to DRAIN.
  - DRAIN: wait until tx_txen==0, then go to ARB. DRAIN never lasts fewer than 2 cycles.
- Truncation at MAX_FRAME: pulse frame_abort in the cycle the forced-last byte is accepted. The grantee's remaining bytes go out as a new frame after re-arbitration.
- Pointer update: the pointer updates only on grant.
- Request timing: requester valid edges during SEND/FLUSH/DRAIN have no effect until ARB.
- Reset mid-frame: all state returns to reset values in the next cycle. The partial byte in the holding register is discarded.

Optional Feature:
MANCH_ARB_PREAMBLE_EN
- Defined: on grant, the holding register is preloaded with PREAMBLE (hold_last=0) before any requester byte is accepted. The preamble does not count toward MAX_FRAME.
- Undefined: a frame starts with the grantee's first byte. The PREAMBLE parameter is unused.

Decomposition:
- Package manch_pkg:
  - arb_state_t enum {ARB, SEND, FLUSH, DRAIN}, 2 bits
  - BYTE_W=8
  - default PREAMBLE constant
- Sub-module manch_rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: winner index, any_valid.

Test Plan:
1. Single frame: req0 sends A5, 3C, FF (last on FF); transmitter model with tx_rdy per byte -> tx_data A5, 3C, FF; tx_valid continuous; DRAIN until tx_txen=0; then ARB with busy=0. With MANCH_ARB_PREAMBLE_EN -> 55, A5, 3C, FF.
2. Contention: req0 and req1 each continuously offer 2-byte frames -> grant_id sequence 0, 1, 0, 1. No bytes interleave within a frame. Each frame is separated by tx_txen low.
3. Same-cycle handoff and load: tx_rdy=1 while req1 presents its next byte -> req_ready=1 that cycle and tx_valid never drops mid-frame.
4. MAX_FRAME=4: req0 sends 6 bytes, last on byte 6 -> first frame is bytes 1-4, with a frame_abort pulse on byte 4. Bytes 5-6 follow as a second frame.
5. Underrun: req0 sends 11, 22, then drops valid with no last -> frame_abort pulse one cycle after hold empties; state goes to DRAIN, then ARB.
6. rst asserted in SEND with hold full -> next cycle tx_valid=0, req_ready=0, state=ARB, grant_id=0.

Source files
------------

// File: rtl/manch_pkg.sv
// Shared types and constants for the Manchester transmitter frame arbiter.
package manch_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DEFAULT_PREAMBLE = 8'h55;

  typedef enum logic [1:0] {
    ARB,
    SEND,
    FLUSH,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/manch_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
module manch_rr_pick #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any_valid
);
  localparam int unsigned PW = $clog2(N_REQ);

  logic [PW-1:0] idx;

  always_comb begin
    winner    = ptr;
    any_valid = 1'b0;
    idx       = '0;
    // i == N_REQ lands back on ptr itself, so the current owner is checked last
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % N_REQ);
      if (!any_valid && req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/manchester_tx_arbiter.sv
// Round-robin frame arbiter feeding one Manchester transmitter from N_REQ byte streams.
// Optional preamble preload on grant is enabled by defining MANCH_ARB_PREAMBLE_EN.
module manchester_tx_arbiter
  import manch_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_FRAME = 16,
  parameter logic [7:0]  PREAMBLE  = DEFAULT_PREAMBLE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_rdy,
  input  logic                     tx_txen,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     frame_abort
);
  localparam int unsigned GW = $clog2(N_REQ);

  arb_state_t        state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [BYTE_W-1:0] hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;
  logic              hold_full_q, hold_full_d;
  logic [7:0]        count_q, count_d;
  logic              drain_first_q, drain_first_d;

  logic [GW-1:0]     pick_winner;
  logic              pick_any;
  logic [BYTE_W-1:0] g_data;
  logic              g_valid, g_last;
  logic              grant_ready, accept, handoff, at_limit;

  manch_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .winner    (pick_winner),
    .any_valid (pick_any)
  );

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        g_data  = req_data[i*BYTE_W +: BYTE_W];
        g_valid = req_valid[i];
        g_last  = req_last[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    hold_data_d   = hold_data_q;
    hold_last_d   = hold_last_q;
    hold_full_d   = hold_full_q;
    count_d       = count_q;
    drain_first_d = 1'b0;
    frame_abort   = 1'b0;
    req_ready     = '0;

    // A held last byte closes acceptance until it has been handed off
    handoff     = hold_full_q && tx_rdy;
    grant_ready = (state_q == SEND) && !(hold_full_q && hold_last_q) &&
                  (!hold_full_q || tx_rdy);
    accept      = grant_ready && g_valid;
    at_limit    = (count_q == 8'(MAX_FRAME - 1));

    if (grant_ready) req_ready[grant_q] = 1'b1;
    if (handoff) hold_full_d = 1'b0;
    if (accept) begin
      hold_data_d = g_data;
      hold_last_d = g_last || at_limit;
      hold_full_d = 1'b1;
      count_d     = count_q + 8'd1;
      if (at_limit && !g_last) frame_abort = 1'b1;
    end

    case (state_q)
      ARB: begin
        if (pick_any) begin
          grant_d = pick_winner;
          ptr_d   = pick_winner;
          count_d = '0;
          state_d = SEND;
`ifdef MANCH_ARB_PREAMBLE_EN
          hold_data_d = PREAMBLE;
          hold_last_d = 1'b0;
          hold_full_d = 1'b1;
`else
          // hold_data is don't-care while the register is empty
          hold_data_d = PREAMBLE;
`endif
        end
      end
      SEND: begin
        if (handoff && hold_last_q) begin
          state_d = FLUSH;
        end else if (!hold_full_q && !g_valid) begin
          frame_abort   = 1'b1;
          state_d       = DRAIN;
          drain_first_d = 1'b1;
        end
      end
      FLUSH: begin
        state_d       = DRAIN;
        drain_first_d = 1'b1;
      end
      DRAIN: begin
        if (!drain_first_q && !tx_txen) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB;
      ptr_q         <= GW'(N_REQ - 1);
      grant_q       <= '0;
      hold_data_q   <= '0;
      hold_last_q   <= 1'b0;
      hold_full_q   <= 1'b0;
      count_q       <= '0;
      drain_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      hold_data_q   <= hold_data_d;
      hold_last_q   <= hold_last_d;
      hold_full_q   <= hold_full_d;
      count_q       <= count_d;
      drain_first_q <= drain_first_d;
    end
  end

  assign tx_valid = hold_full_q;
  assign tx_data  = hold_data_q;
  assign busy     = (state_q != ARB);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_manchester_tx_arbiter.sv
// Directed self-checking bench for manchester_tx_arbiter (N_REQ=2, MAX_FRAME=4).
module tb_manchester_tx_arbiter;
  localparam int unsigned N_REQ     = 2;
  localparam int unsigned MAX_FRAME = 4;
  localparam int unsigned IDLE_BITS = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req_valid, req_last, req_ready;
  logic [8*N_REQ-1:0] req_data;
  logic             tx_valid, tx_rdy, tx_txen, busy, frame_abort;
  logic [7:0]       tx_data;
  logic [0:0]       grant_id;

  manchester_tx_arbiter #(.N_REQ(N_REQ), .MAX_FRAME(MAX_FRAME)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_txen(tx_txen), .busy(busy),
    .grant_id(grant_id), .frame_abort(frame_abort)
  );

  initial forever #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester queues: {last, data}
  logic [8:0] rq0[$];
  logic [8:0] rq1[$];
  logic       rdy_toggle = 1'b0;
  logic       rdy_level  = 1'b1;

  // Requester and transmitter models (act at posedge+1)
  initial begin
    logic [N_REQ-1:0] acc;
    logic             hand;
    logic [8:0]       tmp;
    int unsigned      idle;
    req_valid = '0; req_data = '0; req_last = '0;
    tx_rdy = 1'b0; tx_txen = 1'b0; idle = IDLE_BITS;
    forever begin
      @(negedge clk);
      acc  = req_valid & req_ready;
      hand = tx_valid && tx_rdy;
      @(posedge clk);
      #1;
      if (acc[0] && rq0.size() > 0) tmp = rq0.pop_front();
      if (acc[1] && rq1.size() > 0) tmp = rq1.pop_front();
      if (rst) begin
        tx_txen = 1'b0; idle = IDLE_BITS;
      end else if (hand) begin
        tx_txen = 1'b1; idle = 0;
      end else if (idle < IDLE_BITS) begin
        idle++;
      end else begin
        tx_txen = 1'b0;
      end
      req_valid[0]  = (rq0.size() > 0);
      req_data[7:0] = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
      req_last[0]   = (rq0.size() > 0) ? rq0[0][8] : 1'b0;
      req_valid[1]  = (rq1.size() > 0);
      req_data[15:8] = (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
      req_last[1]   = (rq1.size() > 0) ? rq1[0][8] : 1'b0;
      tx_rdy = rdy_toggle ? !tx_rdy : rdy_level;
    end
  end

  // Observation logs, sampled at negedge
  int unsigned cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  logic [7:0]  log_data[$];
  int unsigned log_frame[$];
  logic [0:0]  grants[$];
  int unsigned frame_no, merge_err, gap_cnt, hl_cnt, abort_cnt;
  int unsigned abort_cyc, last_hand_cyc, fall_cyc, prev_frame;
  logic        abort_acc, have_prev;
  logic [7:0]  abort_byte;

  initial begin
    logic busy_prev;
    logic g_acc;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy && !busy_prev) begin
          frame_no++;
          grants.push_back(grant_id);
          if (tx_txen) merge_err++;
        end
        if (!busy && busy_prev) fall_cyc = cyc;
        g_acc = req_valid[grant_id] && req_ready[grant_id];
        if (tx_valid && tx_rdy) begin
          if (have_prev && prev_frame == frame_no && cyc != last_hand_cyc + 1) gap_cnt++;
          log_data.push_back(tx_data);
          log_frame.push_back(frame_no);
          prev_frame = frame_no; last_hand_cyc = cyc; have_prev = 1'b1;
          if (g_acc) hl_cnt++;
        end
        if (frame_abort) begin
          abort_cnt++;
          abort_cyc  = cyc;
          abort_acc  = g_acc;
          abort_byte = grant_id ? req_data[15:8] : req_data[7:0];
        end
      end
      busy_prev = busy;
    end
  end

  logic [7:0]  exp_data[$];
  int unsigned exp_frame[$];

  task automatic clear_logs();
    log_data.delete(); log_frame.delete(); grants.delete();
    exp_data.delete(); exp_frame.delete();
    frame_no = 0; merge_err = 0; gap_cnt = 0; hl_cnt = 0; abort_cnt = 0;
    abort_cyc = 0; last_hand_cyc = 0; fall_cyc = 0; prev_frame = 0;
    abort_acc = 1'b0; abort_byte = 8'h00; have_prev = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq0.delete(); rq1.delete();
    step(); step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic exp_start(input int unsigned f);
`ifdef MANCH_ARB_PREAMBLE_EN
    exp_data.push_back(8'h55); exp_frame.push_back(f);
`else
    if (f == 0) $display("note: frame index 0 unused");
`endif
  endtask

  task automatic exp_byte(input int unsigned f, input logic [7:0] d);
    exp_data.push_back(d); exp_frame.push_back(f);
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s.len", tag), log_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < log_data.size(); i++) begin
      check($sformatf("%s.byte%0d", tag, i), log_data[i], exp_data[i]);
      check($sformatf("%s.frame%0d", tag, i), log_frame[i], exp_frame[i]);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (rq0.size() == 0 && rq1.size() == 0 && !busy) done = 1'b1;
    end
    check($sformatf("%s.timeout", tag), done, 1'b1);
    step(); step();
  endtask

  initial begin
    logic ok;
    rst = 1'b1;
    clear_logs();
    do_reset();

    // Reset state
    #3;
    check("rst.tx_valid", tx_valid, 0);
    check("rst.tx_data", tx_data, 0);
    check("rst.req_ready", req_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.grant_id", grant_id, 0);
    check("rst.frame_abort", frame_abort, 0);

    // 1: single frame with stalling transmitter
    rdy_toggle = 1'b1;
    rq0.push_back(9'h0A5); rq0.push_back(9'h03C); rq0.push_back(9'h1FF);
    wait_idle("t1");
    exp_start(1); exp_byte(1, 8'hA5); exp_byte(1, 8'h3C); exp_byte(1, 8'hFF);
    check_log("t1");
    check("t1.frames", grants.size(), 1);
    check("t1.grant", grants[0], 0);
    check("t1.drain_latency", fall_cyc - last_hand_cyc, 6);
    check("t1.aborts", abort_cnt, 0);
    rdy_toggle = 1'b0; rdy_level = 1'b1;
    do_reset();

    // 2: contention, two 2-byte frames per requester
    rq0.push_back(9'h001); rq0.push_back(9'h102); rq0.push_back(9'h003); rq0.push_back(9'h104);
    rq1.push_back(9'h011); rq1.push_back(9'h112); rq1.push_back(9'h013); rq1.push_back(9'h114);
    wait_idle("t2");
    exp_start(1); exp_byte(1, 8'h01); exp_byte(1, 8'h02);
    exp_start(2); exp_byte(2, 8'h11); exp_byte(2, 8'h12);
    exp_start(3); exp_byte(3, 8'h03); exp_byte(3, 8'h04);
    exp_start(4); exp_byte(4, 8'h13); exp_byte(4, 8'h14);
    check_log("t2");
    check("t2.frames", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check($sformatf("t2.grant%0d", i), grants[i], i % 2);
    check("t2.merge", merge_err, 0);
    do_reset();

    // 3: same-cycle handoff and load on requester 1
    rq1.push_back(9'h031); rq1.push_back(9'h032); rq1.push_back(9'h133);
    wait_idle("t3");
    exp_start(1); exp_byte(1, 8'h31); exp_byte(1, 8'h32); exp_byte(1, 8'h33);
    check_log("t3");
    check("t3.grant", (grants.size() > 0) ? grants[0] : 1'bx, 1);
    check("t3.gaps", gap_cnt, 0);
`ifdef MANCH_ARB_PREAMBLE_EN
    check("t3.hand_and_load", hl_cnt, 3);
`else
    check("t3.hand_and_load", hl_cnt, 2);
`endif
    do_reset();

    // 4: truncation at MAX_FRAME=4
    for (int i = 1; i <= 6; i++) rq0.push_back({(i == 6) ? 1'b1 : 1'b0, 8'(8'h40 + i)});
    wait_idle("t4");
    exp_start(1);
    for (int i = 1; i <= 4; i++) exp_byte(1, 8'(8'h40 + i));
    exp_start(2); exp_byte(2, 8'h45); exp_byte(2, 8'h46);
    check_log("t4");
    check("t4.aborts", abort_cnt, 1);
    check("t4.abort_on_accept", abort_acc, 1);
    check("t4.abort_byte", abort_byte, 8'h44);
    check("t4.frames", grants.size(), 2);
    do_reset();

    // 5: underrun
    rq0.push_back(9'h011); rq0.push_back(9'h022);
    wait_idle("t5");
    exp_start(1); exp_byte(1, 8'h11); exp_byte(1, 8'h22);
    check_log("t5");
    check("t5.aborts", abort_cnt, 1);
    check("t5.abort_no_accept", abort_acc, 0);
    check("t5.abort_timing", abort_cyc - last_hand_cyc, 1);
    check("t5.busy_after", busy, 0);
    do_reset();

    // 6: reset mid-frame with holding register full
    rdy_level = 1'b0;
    rq1.push_back(9'h0AA); rq1.push_back(9'h1BB);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      if (busy && tx_valid) ok = 1'b1;
    end
    check("t6.setup", ok, 1);
    check("t6.pre_grant", grant_id, 1);
    rst = 1'b1;
    rq1.delete();
    step();
    rst = 1'b0;
    #3;
    check("t6.tx_valid", tx_valid, 0);
    check("t6.req_ready", req_ready, 0);
    check("t6.busy", busy, 0);
    check("t6.grant_id", grant_id, 0);
    check("t6.frame_abort", frame_abort, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
